// File: rtl/brcomp_pkg.sv
// Shared definitions for the branch-compare arbiter.
//   - state_t      : arbiter FSM state encoding
//   - DEF_N        : default operand width
//   - DEF_LAT      : default comparator latency in cycles
//   - cnt_width()  : width of the wait counter for a given latency (>= 1 bit)
package brcomp_pkg;

    localparam int DEF_N   = 32;
    localparam int DEF_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Enough bits to hold the value LAT; a zero-latency build still needs one bit.
    function automatic int cnt_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/brcomp_rr_arb2.sv
// Two-way round-robin picker (purely combinational).
//   valid[1:0]  : request lines
//   last_grant  : index granted most recently
//   grant       : chosen index (meaningful when grant_valid=1)
//   grant_valid : at least one request present
module rr_arb2
    import brcomp_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |valid;
        grant       = 1'b0;
        case (valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            // On a tie the requester that did not win last time goes next.
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/brcomp_arb.sv
// Arbitrates two requesters onto one shared external comparator, with exactly
// one compare in flight.
//   clk_i, rst_i                : clock, synchronous active-high reset
//   reqK_valid_i / reqK_ready_o : request handshake for requester K (0,1)
//   reqK_rs1_i/rs2_i/signed_i   : operands and signedness of requester K
//   rspK_valid_o / rspK_ready_i : response handshake for requester K
//   rsp_less_o, rsp_equal_o     : captured comparator result
//   cmp_rs1_o/rs2_o/signed_o    : operands driven to the external comparator
//   cmp_less_i, cmp_equal_i     : comparator results (valid LAT cycles later)
//   busy_o                      : FSM is not idle
module brcomp_arb
    import brcomp_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int LAT = DEF_LAT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [N-1:0] req0_rs1_i,
    input  logic [N-1:0] req0_rs2_i,
    input  logic         req0_signed_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [N-1:0] req1_rs1_i,
    input  logic [N-1:0] req1_rs2_i,
    input  logic         req1_signed_i,
    output logic         rsp0_valid_o,
    input  logic         rsp0_ready_i,
    output logic         rsp1_valid_o,
    input  logic         rsp1_ready_i,
    output logic         rsp_less_o,
    output logic         rsp_equal_o,
    output logic [N-1:0] cmp_rs1_o,
    output logic [N-1:0] cmp_rs2_o,
    output logic         cmp_signed_o,
    input  logic         cmp_less_i,
    input  logic         cmp_equal_i,
    output logic         busy_o
);

    localparam int             CW      = cnt_width(LAT);
    localparam logic [CW-1:0]  LAT_CNT = CW'(LAT);

    state_t        r_state;
    logic [N-1:0]  r_rs1;
    logic [N-1:0]  r_rs2;
    logic          r_signed;
    logic          r_owner;
    logic          r_last_grant;
    logic          r_less;
    logic          r_equal;
    logic [CW-1:0] r_cnt;

    logic          w_grant;
    logic          w_grant_valid;
    logic          w_idle;
    logic          w_req_hs;
    logic          w_rsp_hs;
    logic          w_in_resp;
    logic [N-1:0]  w_sel_rs1;
    logic [N-1:0]  w_sel_rs2;
    logic          w_sel_signed;

    rr_arb2 u_rr_arb2 (
        .valid       ({req1_valid_i, req0_valid_i}),
        .last_grant  (r_last_grant),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    // Ready is combinational so a request can be taken in the same cycle it
    // appears; it is held off while reset is asserted.
    assign w_idle       = (r_state == ST_IDLE) && !rst_i;
    assign req0_ready_o = w_idle && w_grant_valid && !w_grant;
    assign req1_ready_o = w_idle && w_grant_valid &&  w_grant;
    assign w_req_hs     = (req0_ready_o && req0_valid_i) || (req1_ready_o && req1_valid_i);

    assign w_sel_rs1    = w_grant ? req1_rs1_i    : req0_rs1_i;
    assign w_sel_rs2    = w_grant ? req1_rs2_i    : req0_rs2_i;
    assign w_sel_signed = w_grant ? req1_signed_i : req0_signed_i;

    assign w_in_resp = (r_state == ST_RESP) && !rst_i;
    assign w_rsp_hs  = w_in_resp && (r_owner ? rsp1_ready_i : rsp0_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_signed     <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;   // makes requester 0 win the first tie
            r_less       <= 1'b0;
            r_equal      <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_hs) begin
                        r_rs1    <= w_sel_rs1;
                        r_rs2    <= w_sel_rs2;
                        r_signed <= w_sel_signed;
                        r_owner  <= w_grant;
                        r_cnt    <= LAT_CNT;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Counts LAT..0, so WAIT spans LAT+1 cycles and the
                    // comparator has seen stable operands for LAT cycles.
                    if (r_cnt == '0) begin
                        r_less  <= cmp_less_i;
                        r_equal <= cmp_equal_i;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (w_rsp_hs) begin
                        r_last_grant <= r_owner;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp0_valid_o = w_in_resp && !r_owner;
    assign rsp1_valid_o = w_in_resp &&  r_owner;
    assign rsp_less_o   = r_less;
    assign rsp_equal_o  = r_equal;
    assign cmp_rs1_o    = r_rs1;
    assign cmp_rs2_o    = r_rs2;
    assign cmp_signed_o = r_signed;
    assign busy_o       = (r_state != ST_IDLE) && !rst_i;

endmodule

// File: tb/tb_brcomp_arb.sv
// Bench for brcomp_arb: three instances (LAT = 1, 0, 3) each with a behavioural
// comparator of matching latency. Expected responses are queued at request
// handshake and checked when the response appears.
module tb_brcomp_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic        v0 [3], v1 [3], s0 [3], s1 [3], rr0 [3], rr1 [3];
    logic [31:0] a0 [3], b0 [3], a1 [3], b1 [3];
    logic        rdy0 [3], rdy1 [3], rv0 [3], rv1 [3];
    logic        less [3], eq [3], csg [3], cl [3], ce [3], busy [3];
    logic [31:0] ca [3], cb [3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int last_other_rdy = 0;

    typedef struct {
        int          d;
        int          k;
        bit          sg;
        logic [31:0] a;
        logic [31:0] b;
        bit          el;
        bit          ee;
        int          hs;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int          k;
        bit          sg;
        logic [31:0] a;
        logic [31:0] b;
        bit          el;
        bit          ee;
    } vec_t;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);

        brcomp_arb #(.N(32), .LAT(L)) u_dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .req0_valid_i  (v0[gi]),
            .req0_ready_o  (rdy0[gi]),
            .req0_rs1_i    (a0[gi]),
            .req0_rs2_i    (b0[gi]),
            .req0_signed_i (s0[gi]),
            .req1_valid_i  (v1[gi]),
            .req1_ready_o  (rdy1[gi]),
            .req1_rs1_i    (a1[gi]),
            .req1_rs2_i    (b1[gi]),
            .req1_signed_i (s1[gi]),
            .rsp0_valid_o  (rv0[gi]),
            .rsp0_ready_i  (rr0[gi]),
            .rsp1_valid_o  (rv1[gi]),
            .rsp1_ready_i  (rr1[gi]),
            .rsp_less_o    (less[gi]),
            .rsp_equal_o   (eq[gi]),
            .cmp_rs1_o     (ca[gi]),
            .cmp_rs2_o     (cb[gi]),
            .cmp_signed_o  (csg[gi]),
            .cmp_less_i    (cl[gi]),
            .cmp_equal_i   (ce[gi]),
            .busy_o        (busy[gi])
        );

        // External comparator: result appears L cycles after inputs change.
        logic comb_less, comb_eq;
        logic lp [4];
        logic ep [4];
        always_comb begin
            comb_eq   = (ca[gi] == cb[gi]);
            comb_less = csg[gi] ? ($signed(ca[gi]) < $signed(cb[gi])) : (ca[gi] < cb[gi]);
        end
        always @(posedge clk) begin
            lp[0] <= comb_less;
            ep[0] <= comb_eq;
            for (int i = 1; i < 4; i++) begin
                lp[i] <= lp[i-1];
                ep[i] <= ep[i-1];
            end
        end
        if (L == 0) begin : g_comb
            assign cl[gi] = comb_less;
            assign ce[gi] = comb_eq;
        end else begin : g_pipe
            assign cl[gi] = lp[L-1];
            assign ce[gi] = ep[L-1];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int d, input int k, input bit val, input bit sg,
                           input logic [31:0] a, input logic [31:0] b);
        if (k == 0) begin
            v0[d] = val; s0[d] = sg; a0[d] = a; b0[d] = b;
        end else begin
            v1[d] = val; s1[d] = sg; a1[d] = a; b1[d] = b;
        end
    endtask

    function automatic logic get_rdy(input int d, input int k);
        return (k == 0) ? rdy0[d] : rdy1[d];
    endfunction

    // Called and returns just after a falling edge. Raises valid, waits for
    // ready (bounded), queues the expected response, then drops valid.
    task automatic issue(input int d, input int k, input bit sg, input logic [31:0] a,
                         input logic [31:0] b, input bit el, input bit ee);
        int   n;
        bit   got;
        exp_t e;
        set_req(d, k, 1'b1, sg, a, b);
        #1;
        got = 1'b0;
        n   = 0;
        while (!got && n < 40) begin
            if (get_rdy(d, k)) got = 1'b1;
            else begin
                @(negedge clk); #1; n++;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL issue_timeout d=%0d k=%0d: ready got 0 required 1", d, k);
            set_req(d, k, 1'b0, sg, a, b);
            return;
        end
        last_other_rdy = int'(get_rdy(d, 1 - k));
        e.d = d; e.k = k; e.sg = sg; e.a = a; e.b = b; e.el = el; e.ee = ee;
        e.hs = cyc; e.lat = lat_of(d);
        sbq.push_back(e);
        $display("[TB] req  d=%0d k=%0d signed=%0b rs1=%h rs2=%h accepted cycle %0d",
                 d, k, sg, a, b, cyc);
        @(negedge clk);
        if (k == 0) v0[d] = 1'b0; else v1[d] = 1'b0;
        #1;
    endtask

    // Waits for the next response (bounded), checks it against the queue head,
    // optionally holds rsp ready low for 'hold' cycles, then consumes it.
    task automatic collect(input int d, input int hold);
        int   n;
        bit   got, bad_rdy, bad_cmp, bad_hold;
        exp_t e;
        if (sbq.size() == 0) begin
            tests++; fails++;
            $display("FAIL collect_empty d=%0d: queue size got 0 required >0", d);
            return;
        end
        e        = sbq[0];
        got      = 1'b0;
        bad_rdy  = 1'b0;
        bad_cmp  = 1'b0;
        bad_hold = 1'b0;
        n        = 0;
        while (!got && n < 60) begin
            if (rv0[d] | rv1[d]) got = 1'b1;
            else begin
                if (rdy0[d] | rdy1[d]) bad_rdy = 1'b1;
                if (ca[d] !== e.a || cb[d] !== e.b || csg[d] !== e.sg) bad_cmp = 1'b1;
                @(negedge clk); #1; n++;
            end
        end
        void'(sbq.pop_front());
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL rsp_timeout d=%0d: rsp valid got 0 required 1", d);
            return;
        end
        chk("rsp_latency",       64'(cyc - e.hs), 64'(e.lat + 2));
        chk("rsp_owner_valid",   (e.k == 0) ? rv0[d] : rv1[d], 1);
        chk("rsp_other_valid",   (e.k == 0) ? rv1[d] : rv0[d], 0);
        chk("rsp_less",          less[d], e.el);
        chk("rsp_equal",         eq[d], e.ee);
        chk("req_ready_in_flight", bad_rdy, 0);
        chk("cmp_operands_stable", bad_cmp, 0);
        $display("[TB] rsp  d=%0d k=%0d less=%0b equal=%0b latency=%0d", d, e.k, less[d], eq[d], cyc - e.hs);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            if (((e.k == 0) ? rv0[d] : rv1[d]) !== 1'b1 || less[d] !== e.el ||
                eq[d] !== e.ee || rdy0[d] !== 1'b0 || rdy1[d] !== 1'b0)
                bad_hold = 1'b1;
        end
        if (hold > 0) begin
            chk("rsp_hold_stable", bad_hold, 0);
            v0[d] = 1'b0;
            v1[d] = 1'b0;
        end
        if (e.k == 0) rr0[d] = 1'b1; else rr1[d] = 1'b1;
        @(negedge clk);
        if (e.k == 0) rr0[d] = 1'b0; else rr1[d] = 1'b0;
        #1;
        chk("rsp_valid_drop", rv0[d] | rv1[d], 0);
        chk("busy_after_rsp", busy[d], 0);
    endtask

    task automatic chk_all_zero(input string tag, input int d);
        chk({tag, "_req0_ready"}, rdy0[d], 0);
        chk({tag, "_req1_ready"}, rdy1[d], 0);
        chk({tag, "_rsp0_valid"}, rv0[d], 0);
        chk({tag, "_rsp1_valid"}, rv1[d], 0);
        chk({tag, "_busy"},       busy[d], 0);
        chk({tag, "_less"},       less[d], 0);
        chk({tag, "_equal"},      eq[d], 0);
        chk({tag, "_cmp_rs1"},    ca[d], 0);
        chk({tag, "_cmp_rs2"},    cb[d], 0);
        chk({tag, "_cmp_signed"}, csg[d], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        int   quiet_bad;

        tbl[0] = '{0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0};
        tbl[1] = '{1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0};
        tbl[2] = '{0, 1'b0, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[3] = '{1, 1'b1, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0};
        tbl[4] = '{0, 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0};
        tbl[5] = '{1, 1'b1, 32'h00000005, 32'h00000005, 1'b0, 1'b1};
        tbl[6] = '{0, 1'b1, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
        tbl[7] = '{1, 1'b0, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0};

        // Reset with both requests pending: nothing may be granted.
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            set_req(d, 0, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A);
            set_req(d, 1, 1'b1, 1'b0, 32'h11111111, 32'h22222222);
            rr0[d] = 1'b0;
            rr1[d] = 1'b0;
        end
        @(negedge clk); @(negedge clk); #1;
        chk_all_zero("reset", 0);
        chk_all_zero("reset_lat0", 1);
        chk_all_zero("reset_lat3", 2);

        // First cycle after reset: both valid, req0 wins, req1 waits for rsp0.
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            v0[d] = 1'b0;
            v1[d] = 1'b0;
        end
        set_req(0, 1, 1'b1, 1'b0, 32'h00000010, 32'h00000020);
        issue(0, 0, 1'b0, 32'h00000005, 32'h00000005, 1'b0, 1'b1);
        chk("tie_req1_ready", last_other_rdy, 0);
        collect(0, 0);
        chk("tie_req1_ready_after", rdy1[0], 1);
        issue(0, 1, 1'b0, 32'h00000010, 32'h00000020, 1'b1, 1'b0);
        collect(0, 0);

        // Table-driven compares on the LAT=1 instance.
        for (int i = 0; i < 8; i++) begin
            issue(0, tbl[i].k, tbl[i].sg, tbl[i].a, tbl[i].b, tbl[i].el, tbl[i].ee);
            collect(0, 0);
        end

        // Response back-pressure for 5 cycles; req1 pending and a foreign
        // rsp1 ready asserted throughout must have no effect.
        rr1[0] = 1'b1;
        issue(0, 0, 1'b0, 32'h12345678, 32'h12345678, 1'b0, 1'b1);
        set_req(0, 1, 1'b1, 1'b1, 32'h00000003, 32'h00000004);
        collect(0, 5);
        rr1[0] = 1'b0;

        // Reset during WAIT discards the transaction.
        issue(0, 0, 1'b1, 32'h00000001, 32'h00000002, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk); #1;
        chk_all_zero("midreset", 0);
        rst = 1'b0;
        void'(sbq.pop_back());
        quiet_bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (rv0[0] | rv1[0] | busy[0]) quiet_bad = 1;
        end
        chk("midreset_no_response", quiet_bad, 0);
        issue(0, 1, 1'b0, 32'h00000007, 32'h00000003, 1'b0, 1'b0);
        collect(0, 0);

        // Latency sweep across LAT = 1, 0, 3.
        for (int d = 0; d < 3; d++) begin
            issue(d, 0, 1'b1, 32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b0);
            collect(d, 0);
            issue(d, 1, 1'b0, 32'hFFFFFFFE, 32'h00000003, 1'b0, 1'b0);
            collect(d, 0);
        end

        chk("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/brcomp_arb.md
BRCOMP_ARB -- requirements
Module: brcomp_arb

Interface
REQ-001 Parameter N, default 32, operand width.
REQ-002 Parameter LAT, default 1, comparator result latency in cycles after its inputs change (0 = combinational).
REQ-003 clk_i  input  1  the single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 reqk_valid_i (k=0,1)  input  1  requester k has a compare pending.
REQ-006 reqk_ready_o (k=0,1)  output  1  arbiter accepts requester k this cycle.
REQ-007 reqk_rs1_i, reqk_rs2_i (k=0,1)  input  N  operands.
REQ-008 reqk_signed_i (k=0,1)  input  1  1 = signed compare, 0 = unsigned.
REQ-009 rspk_valid_o (k=0,1)  output  1  result for requester k available.
REQ-010 rspk_ready_i (k=0,1)  input  1  requester k consumes result.
REQ-011 rsp_less_o, rsp_equal_o  output  1 each  captured comparator result, meaningful when any rspk_valid_o=1.
REQ-012 cmp_rs1_o, cmp_rs2_o  output  N  operands driven to the shared comparator.
REQ-013 cmp_signed_o  output  1  signedness driven to the comparator.
REQ-014 cmp_less_i, cmp_equal_i  input  1 each  comparator results.
REQ-015 busy_o  output  1  high in every state except IDLE.

Function
REQ-016 FSM states IDLE, WAIT, RESP; exactly one compare in flight.
REQ-017 IDLE: if exactly one reqk_valid_i=1, grant k; if both, grant the requester other than last_grant; reqk_ready_o=1 only for the granted k, combinationally, only in IDLE.
REQ-018 Handshake (valid & ready) latches rs1, rs2, signed and owner into registers, loads wait counter with LAT, and moves to WAIT.
REQ-019 cmp_rs1_o/cmp_rs2_o/cmp_signed_o come from the latched registers only and remain stable from the cycle after handshake until return to IDLE.
REQ-020 WAIT lasts exactly LAT+1 cycles; on the final WAIT cycle cmp_less_i/cmp_equal_i are captured into rsp_less_o/rsp_equal_o and state moves to RESP.
REQ-021 RESP: rsp<owner>_valid_o=1, the other rsp valid=0; outputs held stable until rsp<owner>_ready_i=1.
REQ-022 On response handshake: last_grant <= owner, state <= IDLE, rsp valid drops next cycle.
REQ-023 Latency: request handshake in cycle T gives rsp valid in cycle T+LAT+2; minimum issue interval LAT+3 cycles.
REQ-024 rsp ready held low: remain in RESP indefinitely; both reqk_ready_o stay 0.
REQ-025 Requester inputs while not granted are ignored; requester holds valid and operands until ready.
REQ-026 rspk_ready_i asserted for a non-owner or outside RESP has no effect.
REQ-027 Wait counter width is clog2(LAT+1), minimum 1 bit; no wrap beyond LAT.

Reset
REQ-028 rst_i=1 at an edge forces IDLE, last_grant=1 (req0 wins the first tie), and clears all registers: operands, signed, owner, rsp_less_o, rsp_equal_o, counter.
REQ-029 While rst_i=1 all outputs are 0, including reqk_ready_o.
REQ-030 Reset mid-operation (WAIT or RESP) discards the transaction silently; no response is issued afterwards.

Structure
REQ-031 Package brcomp_pkg holds the state enum typedef and the default N and LAT constants.
REQ-032 One sub-module, rr_arb2: a combinational 2-way round-robin picker with inputs valid[1:0] and last_grant and outputs grant and grant_valid.
REQ-033 The comparator is external to this block; brcomp connects through the cmp_* ports.

Verification
REQ-034 LAT=1; req0 signed, rs1=0xFFFFFFFF, rs2=0x00000001, handshake at T -> rsp0_valid at T+3, less=1, equal=0; rsp1_valid stays 0.
REQ-035 Same operands, unsigned, on req1 -> rsp1_valid, less=0, equal=0.
REQ-036 Both valid in the first cycle after reset -> req0 granted first; req1_ready=1 only after the rsp0 handshake; results return as rsp0 then rsp1.
REQ-037 rs1=rs2=0x12345678, rsp0_ready held low 5 cycles -> rsp0_valid, less=0, equal=1 stable all 5 cycles; req1_ready=0 throughout.
REQ-038 rst_i pulsed during WAIT -> next cycle all outputs 0, no response; next single req1 completes normally.
REQ-039 Sweep LAT = 0, 1, 3 -> response latency exactly LAT+2 cycles after the request handshake.
